control_sequencer: RTL and testbench



---
 rtl/avr_ctrl_pkg.sv | 81 ++++++++
 rtl/ctrl_select_decode.sv | 114 +++++++++++
 rtl/control_sequencer.sv | 136 +++++++++++++
 tb/tb_control_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_ctrl_pkg.sv
// rtl/avr_ctrl_pkg.sv - shared IDs, select encodings and states for the AVR control sequencer
package avr_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_EXEC     = 2'd1;
  localparam state_t ST_IRQ_PUSH = 2'd2;
  localparam state_t ST_IRQ_VEC  = 2'd3;

  localparam logic [31:0] ID_BR_FIRST  = 32'h04;
  localparam logic [31:0] ID_BR_LAST   = 32'h08;
  localparam logic [31:0] ID_SREG_ST_A = 32'h0A;
  localparam logic [31:0] ID_ALU_IMM_A = 32'h0D;
  localparam logic [31:0] ID_IO_ADDR   = 32'h11;
  localparam logic [31:0] ID_LD        = 32'h19;
  localparam logic [31:0] ID_LDI       = 32'h20;
  localparam logic [31:0] ID_MOV_RD2   = 32'h22;
  localparam logic [31:0] ID_SP_LOAD   = 32'h29;
  localparam logic [31:0] ID_POP       = 32'h2A;
  localparam logic [31:0] ID_PUSH      = 32'h2B;
  localparam logic [31:0] ID_RCALL     = 32'h2C;
  localparam logic [31:0] ID_RET       = 32'h2D;
  localparam logic [31:0] ID_RETI      = 32'h2E;
  localparam logic [31:0] ID_JUMP_ABS  = 32'h2F;
  localparam logic [31:0] ID_SREG_ST_B = 32'h32;
  localparam logic [31:0] ID_ST        = 32'h38;
  localparam logic [31:0] ID_ALU_IMM_B = 32'h41;

  localparam logic [2:0] MM_ADDR_RF     = 3'd0;
  localparam logic [2:0] MM_ADDR_IO     = 3'd1;
  localparam logic [2:0] MM_ADDR_SP     = 3'd2;
  localparam logic [2:0] MM_ADDR_SP_INC = 3'd3;
  localparam logic [2:0] MM_ADDR_SREG   = 3'd4;

  localparam logic [2:0] MM_DATA_RD1     = 3'd0;
  localparam logic [2:0] MM_DATA_PC_LO   = 3'd1;
  localparam logic [2:0] MM_DATA_PC_HI   = 3'd2;
  localparam logic [2:0] MM_DATA_SREG_NI = 3'd3;
  localparam logic [2:0] MM_DATA_PC_EXT  = 3'd4;

  localparam logic       ALU1_RF  = 1'b0;
  localparam logic       ALU1_SP  = 1'b1;
  localparam logic [1:0] ALU2_RF  = 2'd0;
  localparam logic [1:0] ALU2_IMM = 2'd1;
  localparam logic [1:0] ALU2_ONE = 2'd2;

  localparam logic       RF_WA_RD  = 1'b0;
  localparam logic       RF_WA_ALT = 1'b1;
  localparam logic [2:0] RF_WD_ALU = 3'd0;
  localparam logic [2:0] RF_WD_MEM = 3'd1;
  localparam logic [2:0] RF_WD_IMM = 3'd2;
  localparam logic [2:0] RF_WD_RD2 = 3'd3;

  localparam logic [1:0] PC_NEW_VEC = 2'd0;
  localparam logic [1:0] PC_NEW_REL = 2'd1;
  localparam logic [1:0] PC_NEW_ABS = 2'd2;

  typedef struct packed {
    logic       sp_inl_sel;
    logic [2:0] mm_addr_sel;
    logic [2:0] mm_data_sel;
    logic       alu_arg1_sel;
    logic [1:0] alu_arg2_sel;
    logic       rf_wa_sel;
    logic [2:0] rf_wd_sel;
    logic [1:0] pc_new_sel;
    logic       mm_we;
    logic       sp_we;
  } sel_t;

  // Number of execute cycles an instruction occupies.
  function automatic logic [2:0] seq_len(input logic [31:0] id, input int pc_bytes);
    case (id)
      ID_PUSH, ID_POP, ID_LD, ID_ST: return 3'd2;
      ID_RCALL, ID_RET, ID_RETI:     return 3'(pc_bytes + 1);
      default:                       return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_select_decode.sv
// rtl/ctrl_select_decode.sv - combinational (state, stage, id) to datapath select vector
module ctrl_select_decode
  import avr_ctrl_pkg::*;
#(
  parameter int ID_W     = 8,
  parameter int PC_BYTES = 2
) (
  input  state_t          state,
  input  logic [1:0]      stage,
  input  logic [ID_W-1:0] id,
  output sel_t            sel
);

  logic [31:0] idx;
  logic [2:0]  len;
  logic        last;

  assign idx  = 32'(id);
  assign len  = seq_len(idx, PC_BYTES);
  assign last = ({1'b0, stage} == len - 3'd1);

  // Return-address bytes go out low first, extension byte last.
  function automatic logic [2:0] push_data(input logic [1:0] stg);
    case (stg)
      2'd0:    return MM_DATA_PC_LO;
      2'd1:    return MM_DATA_PC_HI;
      default: return MM_DATA_PC_EXT;
    endcase
  endfunction

  always_comb begin
    sel = '0;
    case (state)
      ST_EXEC: begin
        case (idx) inside
          ID_LD, ID_ST: begin
            if (stage == 2'd0) begin
              sel.mm_addr_sel = MM_ADDR_RF;
              sel.rf_wa_sel   = RF_WA_ALT;
              if (idx == ID_ST) begin
                sel.rf_wd_sel = RF_WD_MEM;
                sel.mm_we     = 1'b1;
              end
            end
          end
          ID_PUSH: begin
            if (stage == 2'd0) begin
              sel.mm_addr_sel = MM_ADDR_SP;
              sel.mm_we       = 1'b1;
            end else begin
              sel.alu_arg1_sel = ALU1_SP;
              sel.alu_arg2_sel = ALU2_ONE;
              sel.sp_we        = 1'b1;
            end
          end
          ID_POP: begin
            if (stage == 2'd0) begin
              sel.alu_arg1_sel = ALU1_SP;
              sel.alu_arg2_sel = ALU2_ONE;
              sel.sp_we        = 1'b1;
            end else begin
              sel.mm_addr_sel = MM_ADDR_SP_INC;
            end
          end
          ID_RCALL: begin
            if (last) begin
              sel.pc_new_sel = PC_NEW_ABS;
            end else begin
              sel.mm_data_sel = push_data(stage);
              sel.mm_we       = 1'b1;
              sel.sp_we       = 1'b1;
            end
          end
          ID_RET, ID_RETI: begin
            if (!last) begin
              sel.alu_arg2_sel = ALU2_ONE;
              sel.sp_we        = 1'b1;
            end
          end
          ID_ALU_IMM_A, ID_ALU_IMM_B: sel.alu_arg2_sel = ALU2_IMM;
          [ID_BR_FIRST:ID_BR_LAST]:   sel.pc_new_sel   = PC_NEW_REL;
          ID_JUMP_ABS:                sel.pc_new_sel   = PC_NEW_ABS;
          ID_SREG_ST_A, ID_SREG_ST_B: begin
            sel.mm_addr_sel = MM_ADDR_SREG;
            sel.mm_data_sel = MM_DATA_SREG_NI;
            sel.mm_we       = 1'b1;
          end
          ID_IO_ADDR: sel.mm_addr_sel = MM_ADDR_IO;
          ID_SP_LOAD: begin
            sel.mm_addr_sel = MM_ADDR_IO;
            sel.sp_inl_sel  = 1'b1;
          end
          ID_LDI:     sel.rf_wd_sel = RF_WD_IMM;
          ID_MOV_RD2: sel.rf_wd_sel = RF_WD_RD2;
          default: ;
        endcase
      end
      ST_IRQ_PUSH: begin
        sel.mm_data_sel = push_data(stage);
        sel.mm_we       = 1'b1;
        sel.sp_we       = 1'b1;
      end
      ST_IRQ_VEC: begin
        // The SREG write with I inverted is what masks further interrupts.
        sel.pc_new_sel  = PC_NEW_VEC;
        sel.mm_addr_sel = MM_ADDR_SREG;
        sel.mm_data_sel = MM_DATA_SREG_NI;
        sel.mm_we       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle AVR control sequencer with interrupt entry
module control_sequencer
  import avr_ctrl_pkg::*;
#(
  parameter int ID_W     = 8,
  parameter int PC_BYTES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [ID_W-1:0] instruction_id,
  input  logic            irq_req,
  input  logic            i_flag,
  output logic            busy,
  output logic            instr_done,
  output logic            irq_ack,
  output logic [1:0]      stage,
  output logic            mm_we,
  output logic            sp_we,
  output logic            sp_inl_sel,
  output logic [2:0]      mm_addr_sel,
  output logic            alu_arg1_sel,
  output logic [1:0]      alu_arg2_sel,
  output logic            rf_wa_sel,
  output logic [2:0]      rf_wd_sel,
  output logic [1:0]      pc_new_sel,
  output logic [2:0]      mm_data_sel
);

  if (PC_BYTES != 2 && PC_BYTES != 3) begin : g_bad_pc_bytes
    $error("control_sequencer: PC_BYTES must be 2 or 3");
  end

  state_t          state_q, state_d;
  logic [1:0]      stage_q, stage_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [2:0]      cur_len, nxt_len;
  logic            last_cycle;
  logic            irq_take;
  sel_t            sel_d, sel_q;
  logic            done_d, ack_d;

  assign cur_len    = seq_len(32'(id_q), PC_BYTES);
  assign nxt_len    = seq_len(32'(id_d), PC_BYTES);
  assign last_cycle = (state_q == ST_EXEC) && ({1'b0, stage_q} == cur_len - 3'd1);
  assign irq_take   = irq_req && i_flag;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE, ST_EXEC: begin
        if (state_q == ST_IDLE || last_cycle) begin
          // Instruction boundary: a pending enabled interrupt wins and the
          // instruction stays held on the decoder until we come back.
          stage_d = 2'd0;
          if (irq_take) begin
            state_d = ST_IRQ_PUSH;
          end else if (instr_valid) begin
            state_d = ST_EXEC;
            id_d    = instruction_id;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          stage_d = stage_q + 2'd1;
        end
      end
      ST_IRQ_PUSH: begin
        if (stage_q == 2'(PC_BYTES - 1)) begin
          state_d = ST_IRQ_VEC;
          stage_d = 2'd0;
        end else begin
          stage_d = stage_q + 2'd1;
        end
      end
      default: begin
        // A held instruction starts straight after the vector cycle.
        stage_d = 2'd0;
        if (instr_valid) begin
          state_d = ST_EXEC;
          id_d    = instruction_id;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  ctrl_select_decode #(
    .ID_W     (ID_W),
    .PC_BYTES (PC_BYTES)
  ) u_decode (
    .state (state_d),
    .stage (stage_d),
    .id    (id_d),
    .sel   (sel_d)
  );

  assign done_d = (state_d == ST_EXEC) && ({1'b0, stage_d} == nxt_len - 3'd1);
  assign ack_d  = (state_d == ST_IRQ_PUSH) && (stage_d == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      stage_q    <= 2'd0;
      id_q       <= '0;
      sel_q      <= '0;
      busy       <= 1'b0;
      instr_done <= 1'b0;
      irq_ack    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      id_q       <= id_d;
      sel_q      <= sel_d;
      busy       <= (state_d != ST_IDLE);
      instr_done <= done_d;
      irq_ack    <= ack_d;
    end
  end

  assign stage        = stage_q;
  assign mm_we        = sel_q.mm_we;
  assign sp_we        = sel_q.sp_we;
  assign sp_inl_sel   = sel_q.sp_inl_sel;
  assign mm_addr_sel  = sel_q.mm_addr_sel;
  assign alu_arg1_sel = sel_q.alu_arg1_sel;
  assign alu_arg2_sel = sel_q.alu_arg2_sel;
  assign rf_wa_sel    = sel_q.rf_wa_sel;
  assign rf_wd_sel    = sel_q.rf_wd_sel;
  assign pc_new_sel   = sel_q.pc_new_sel;
  assign mm_data_sel  = sel_q.mm_data_sel;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed table-driven bench for control_sequencer at PC_BYTES 2 and 3
module tb_control_sequencer;

  typedef logic [22:0] obs_t;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       irq;
    logic       ifl;
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instruction_id = 8'h00;
  logic       irq_req = 1'b0;
  logic       i_flag = 1'b0;

  logic       busy2, done2, ack2, we2, spwe2, inl2, a1_2, wa2;
  logic [1:0] stg2, a2_2, pcn2;
  logic [2:0] maddr2, wd2, mdata2;
  logic       busy3, done3, ack3, we3, spwe3, inl3, a1_3, wa3;
  logic [1:0] stg3, a2_3, pcn3;
  logic [2:0] maddr3, wd3, mdata3;
  obs_t       obs2, obs3;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  control_sequencer #(.ID_W(8), .PC_BYTES(2)) dut2 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction_id(instruction_id),
    .irq_req(irq_req), .i_flag(i_flag), .busy(busy2), .instr_done(done2), .irq_ack(ack2),
    .stage(stg2), .mm_we(we2), .sp_we(spwe2), .sp_inl_sel(inl2), .mm_addr_sel(maddr2),
    .alu_arg1_sel(a1_2), .alu_arg2_sel(a2_2), .rf_wa_sel(wa2), .rf_wd_sel(wd2),
    .pc_new_sel(pcn2), .mm_data_sel(mdata2)
  );

  control_sequencer #(.ID_W(8), .PC_BYTES(3)) dut3 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction_id(instruction_id),
    .irq_req(irq_req), .i_flag(i_flag), .busy(busy3), .instr_done(done3), .irq_ack(ack3),
    .stage(stg3), .mm_we(we3), .sp_we(spwe3), .sp_inl_sel(inl3), .mm_addr_sel(maddr3),
    .alu_arg1_sel(a1_3), .alu_arg2_sel(a2_3), .rf_wa_sel(wa3), .rf_wd_sel(wd3),
    .pc_new_sel(pcn3), .mm_data_sel(mdata3)
  );

  assign obs2 = {busy2, done2, ack2, stg2, we2, spwe2, inl2, maddr2, a1_2, a2_2, wa2, wd2, pcn2, mdata2};
  assign obs3 = {busy3, done3, ack3, stg3, we3, spwe3, inl3, maddr3, a1_3, a2_3, wa3, wd3, pcn3, mdata3};

  // Argument order matches the observed vector: busy done ack stage mm_we sp_we
  // sp_inl mm_addr alu1 alu2 rf_wa rf_wd pc_new mm_data.
  function automatic obs_t ex(input int busy, input int done, input int ack, input int stg,
                              input int we, input int spwe, input int inl, input int maddr,
                              input int a1, input int a2, input int wa, input int wd,
                              input int pcn, input int mdata);
    return {1'(busy), 1'(done), 1'(ack), 2'(stg), 1'(we), 1'(spwe), 1'(inl), 3'(maddr),
            1'(a1), 2'(a2), 1'(wa), 3'(wd), 2'(pcn), 3'(mdata)};
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic irq, input logic ifl);
    instr_valid    = iv;
    instruction_id = id;
    irq_req        = irq;
    i_flag         = ifl;
  endtask

  task automatic add(input logic iv, input logic [7:0] id, input logic irq, input logic ifl, input obs_t exp);
    vec_t v;
    v.iv = iv; v.id = id; v.irq = irq; v.ifl = ifl; v.exp = exp;
    tbl.push_back(v);
  endtask

  obs_t vec_o, push_s0, push_s1, push_s2;
  obs_t e2, e3;

  initial begin
    vec_o   = ex(1,0,0,0, 1,0,0,4, 0,0,0,0,0,3);
    push_s0 = ex(1,0,0,0, 1,1,0,0, 0,0,0,0,0,1);
    push_s1 = ex(1,0,0,1, 1,1,0,0, 0,0,0,0,0,2);
    push_s2 = ex(1,0,0,2, 1,1,0,0, 0,0,0,0,0,4);

    add(1, 8'h20, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,0,0,2,0,0));
    add(1, 8'h0D, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,1,0,0,0,0));
    add(1, 8'h41, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,1,0,0,0,0));
    add(1, 8'h03, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,0,0,0,0,0));
    add(1, 8'h04, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,0,0,0,1,0));
    add(1, 8'h08, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,0,0,0,1,0));
    add(1, 8'h09, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,0,0,0,0,0));
    add(1, 8'h2F, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,0,0,0,2,0));
    add(1, 8'h0A, 0, 0, ex(1,1,0,0, 1,0,0,4, 0,0,0,0,0,3));
    add(1, 8'h32, 0, 0, ex(1,1,0,0, 1,0,0,4, 0,0,0,0,0,3));
    add(1, 8'h11, 0, 0, ex(1,1,0,0, 0,0,0,1, 0,0,0,0,0,0));
    add(1, 8'h29, 0, 0, ex(1,1,0,0, 0,0,1,1, 0,0,0,0,0,0));
    add(1, 8'h22, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,0,0,3,0,0));
    add(0, 8'h00, 0, 0, '0);
    add(1, 8'h2B, 0, 0, ex(1,0,0,0, 1,0,0,2, 0,0,0,0,0,0));
    add(1, 8'h20, 0, 0, ex(1,1,0,1, 0,1,0,0, 1,2,0,0,0,0));
    add(1, 8'h20, 0, 0, ex(1,1,0,0, 0,0,0,0, 0,0,0,2,0,0));
    add(1, 8'h38, 0, 0, ex(1,0,0,0, 1,0,0,0, 0,0,1,1,0,0));
    add(0, 8'h00, 0, 0, ex(1,1,0,1, 0,0,0,0, 0,0,0,0,0,0));
    add(1, 8'h19, 0, 0, ex(1,0,0,0, 0,0,0,0, 0,0,1,0,0,0));
    add(0, 8'h00, 0, 0, ex(1,1,0,1, 0,0,0,0, 0,0,0,0,0,0));
    add(1, 8'h2A, 0, 0, ex(1,0,0,0, 0,1,0,0, 1,2,0,0,0,0));
    add(0, 8'h00, 0, 0, ex(1,1,0,1, 0,0,0,3, 0,0,0,0,0,0));
    add(0, 8'h00, 1, 0, '0);
    add(1, 8'h41, 1, 0, ex(1,1,0,0, 0,0,0,0, 0,1,0,0,0,0));
    add(0, 8'h00, 1, 0, '0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc2", obs2, '0);
    chk("reset_pc3", obs3, '0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].irq, tbl[i].ifl);
      step();
      chk($sformatf("vec%0d_pc2", i), obs2, tbl[i].exp);
      chk($sformatf("vec%0d_pc3", i), obs3, tbl[i].exp);
    end

    // RCALL: three pushes then the jump at PC_BYTES=3, two pushes at PC_BYTES=2.
    drive(1, 8'h2C, 0, 0);
    step();
    drive(0, 8'h00, 0, 0);
    chk("rcall_s0_pc2", obs2, push_s0);
    chk("rcall_s0_pc3", obs3, push_s0);
    step();
    chk("rcall_s1_pc2", obs2, push_s1);
    chk("rcall_s1_pc3", obs3, push_s1);
    step();
    chk("rcall_s2_pc2", obs2, ex(1,1,0,2, 0,0,0,0, 0,0,0,0,2,0));
    chk("rcall_s2_pc3", obs3, push_s2);
    step();
    chk("rcall_s3_pc2", obs2, '0);
    chk("rcall_s3_pc3", obs3, ex(1,1,0,3, 0,0,0,0, 0,0,0,0,2,0));
    step();
    chk("rcall_end_pc3", obs3, '0);

    // RET: SP increments on every stage but the last.
    drive(1, 8'h2D, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      drive(0, 8'h00, 0, 0);
      e2 = (k < 2) ? ex(1,0,0,k, 0,1,0,0, 0,2,0,0,0,0) : (k == 2) ? ex(1,1,0,2, 0,0,0,0, 0,0,0,0,0,0) : '0;
      e3 = (k < 3) ? ex(1,0,0,k, 0,1,0,0, 0,2,0,0,0,0) : ex(1,1,0,3, 0,0,0,0, 0,0,0,0,0,0);
      chk($sformatf("ret_s%0d_pc2", k), obs2, e2);
      chk($sformatf("ret_s%0d_pc3", k), obs3, e3);
    end
    step();

    // Asynchronous reset in RCALL stage 1 discards the sequence.
    drive(1, 8'h2C, 0, 0);
    step();
    drive(0, 8'h00, 0, 0);
    step();
    chk("prerst_s1_pc2", obs2, push_s1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pc2", obs2, '0);
    chk("async_rst_pc3", obs3, '0);
    step();
    chk("held_rst_pc2", obs2, '0);
    reset = 1'b0;
    drive(1, 8'h20, 0, 0);
    step();
    drive(0, 8'h00, 0, 0);
    chk("first_after_rst_pc2", obs2, ex(1,1,0,0, 0,0,0,0, 0,0,0,2,0,0));
    chk("first_after_rst_pc3", obs3, ex(1,1,0,0, 0,0,0,0, 0,0,0,2,0,0));
    step();

    // Interrupt raised during POP is taken at the POP instr_done boundary.
    drive(1, 8'h2A, 0, 0);
    step();
    drive(0, 8'h00, 1, 1);
    chk("irqpop_s0", obs2, ex(1,0,0,0, 0,1,0,0, 1,2,0,0,0,0));
    step();
    chk("irqpop_s1_pc2", obs2, ex(1,1,0,1, 0,0,0,3, 0,0,0,0,0,0));
    chk("irqpop_s1_pc3", obs3, ex(1,1,0,1, 0,0,0,3, 0,0,0,0,0,0));
    step();
    drive(0, 8'h00, 0, 0);
    chk("irqpop_ack_pc2", obs2, ex(1,0,1,0, 1,1,0,0, 0,0,0,0,0,1));
    chk("irqpop_ack_pc3", obs3, ex(1,0,1,0, 1,1,0,0, 0,0,0,0,0,1));
    step();
    chk("irqpop_p1_pc2", obs2, push_s1);
    chk("irqpop_p1_pc3", obs3, push_s1);
    step();
    chk("irqpop_vec_pc2", obs2, vec_o);
    chk("irqpop_p2_pc3", obs3, push_s2);
    step();
    chk("irqpop_idle_pc2", obs2, '0);
    chk("irqpop_vec_pc3", obs3, vec_o);
    step();
    chk("irqpop_idle_pc3", obs3, '0);

    // instr_valid and irq together in IDLE: interrupt first, LDI held.
    drive(1, 8'h20, 1, 1);
    step();
    drive(1, 8'h20, 0, 0);
    chk("irqfirst_ack_pc2", obs2, ex(1,0,1,0, 1,1,0,0, 0,0,0,0,0,1));
    chk("irqfirst_ack_pc3", obs3, ex(1,0,1,0, 1,1,0,0, 0,0,0,0,0,1));
    step();
    chk("irqfirst_p1_pc2", obs2, push_s1);
    step();
    chk("irqfirst_vec_pc2", obs2, vec_o);
    chk("irqfirst_p2_pc3", obs3, push_s2);
    step();
    chk("irqfirst_ldi_pc2", obs2, ex(1,1,0,0, 0,0,0,0, 0,0,0,2,0,0));
    chk("irqfirst_vec_pc3", obs3, vec_o);
    drive(1, 8'h20, 0, 0);
    step();
    chk("irqfirst_ldi_pc3", obs3, ex(1,1,0,0, 0,0,0,2*0, 0,0,0,2,0,0));
    drive(0, 8'h00, 0, 0);
    step();
    chk("final_idle_pc2", obs2, '0);
    chk("final_idle_pc3", obs3, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
